// File: rtl/option_queue.sv
// option_queue: circular replay queue on the transmitter side of the line solver's option stream.
// It is loaded once, replays entries, requeues options by verdict and keeps per-line option counts.
module option_queue #(
    parameter int SIZE  = 3,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic                     load_is_index,
    input  logic [SIZE-1:0]          load_data,
    output logic                     load_ready,
    input  logic                     load_done,
    output logic [SIZE-1:0]          option,
    output logic                     option_is_index,
    output logic                     valid_op,
    input  logic                     valid_out,
    input  logic                     put_back_to_FIFO,
    output logic [2*SIZE:0][6:0]     old_options_amnt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   CAP      = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [SIZE-1:0] LINE_MAX = SIZE'(2 * SIZE);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [SIZE:0]   mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [SIZE-1:0] load_line;
    logic [SIZE-1:0] cur_line;
    logic            first_pass_done;
    logic            discard_seen;

    logic [SIZE:0]   head_entry;
    logic            head_is_index;
    logic [SIZE-1:0] head_data;
    logic            load_fire;
    logic            stop_here;
    logic            wr_en;
    logic [SIZE:0]   wr_data;

    assign head_entry    = mem[head];
    assign head_is_index = head_entry[SIZE];
    assign head_data     = head_entry[SIZE-1:0];
    assign load_ready    = (state == ST_LOAD) && (count < CAP);
    assign load_fire     = load_valid && load_ready;
    // A pass that eliminated nothing ends the solve at the next line-0 marker.
    assign stop_here     = head_is_index && (head_data == '0) && first_pass_done && !discard_seen;

    // Single tail write port: load, index recirculation, or kept option.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = head_entry;
        case (state)
            ST_LOAD: begin
                if (load_fire) begin
                    wr_en   = 1'b1;
                    wr_data = {load_is_index, load_data};
                end else begin
                    wr_en = 1'b0;
                end
            end
            ST_ISSUE: begin
                if ((count != '0) && head_is_index && !stop_here) begin
                    wr_en = 1'b1;
                end else begin
                    wr_en = 1'b0;
                end
            end
            ST_WAIT: begin
                if (valid_out && put_back_to_FIFO) begin
                    wr_en   = 1'b1;
                    wr_data = {1'b0, option};
                end else begin
                    wr_en = 1'b0;
                end
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Queue storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[tail] <= wr_data;
        end
    end

    // Control FSM, pointers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_LOAD;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            load_line        <= '0;
            cur_line         <= '0;
            first_pass_done  <= 1'b0;
            discard_seen     <= 1'b0;
            option           <= '0;
            option_is_index  <= 1'b0;
            valid_op         <= 1'b0;
            done             <= 1'b0;
            old_options_amnt <= '0;
        end else begin
            valid_op <= 1'b0;
            if (wr_en) begin
                tail <= tail + PTR_ONE;
            end
            case (state)
                ST_LOAD: begin
                    if (load_fire) begin
                        count <= count + CNT_ONE;
                        if (load_is_index) begin
                            load_line <= load_data;
                        end else if ((load_line <= LINE_MAX) &&
                                     (old_options_amnt[load_line] != 7'd127)) begin
                            old_options_amnt[load_line] <= old_options_amnt[load_line] + 7'd1;
                        end
                    end
                    if (load_done && (count != '0)) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if ((count == '0) || stop_here) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (head_is_index) begin
                        valid_op        <= 1'b1;
                        option          <= head_data;
                        option_is_index <= 1'b1;
                        head            <= head + PTR_ONE;
                        cur_line        <= head_data;
                        if (head_data == '0) begin
                            first_pass_done <= 1'b1;
                            discard_seen    <= 1'b0;
                        end
                    end else begin
                        valid_op        <= 1'b1;
                        option          <= head_data;
                        option_is_index <= 1'b0;
                        head            <= head + PTR_ONE;
                        count           <= count - CNT_ONE;
                        state           <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (valid_out) begin
                        if (put_back_to_FIFO) begin
                            count <= count + CNT_ONE;
                        end else begin
                            discard_seen <= 1'b1;
                            if ((cur_line <= LINE_MAX) && (old_options_amnt[cur_line] != 7'd0)) begin
                                old_options_amnt[cur_line] <= old_options_amnt[cur_line] - 7'd1;
                            end
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_option_queue.sv
// Self-checking bench for option_queue: a queue-level reference model predicts every issue,
// count and per-line option total while the bench plays the solver.
module tb_option_queue;

    localparam int SIZE = 3;
    localparam int NL   = 2 * SIZE + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1;
    logic                load_valid = 1'b0, load_is_index = 1'b0, load_done = 1'b0;
    logic [SIZE-1:0]     load_data = '0;
    logic                valid_out = 1'b0, put_back = 1'b0;
    logic                load_ready, option_is_index, valid_op, done;
    logic [SIZE-1:0]     option;
    logic [2*SIZE:0][6:0] amnt;
    logic [6:0]          count;

    logic                s_load_valid = 1'b0, s_load_is_index = 1'b0, s_load_done = 1'b0;
    logic [SIZE-1:0]     s_load_data = '0;
    logic                s_valid_out = 1'b0, s_put_back = 1'b0;
    logic                s_load_ready, s_option_is_index, s_valid_op, s_done;
    logic [SIZE-1:0]     s_option;
    logic [2*SIZE:0][6:0] s_amnt;
    logic [2:0]          s_count;

    option_queue #(.SIZE(SIZE), .DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_is_index(load_is_index), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done),
        .option(option), .option_is_index(option_is_index), .valid_op(valid_op),
        .valid_out(valid_out), .put_back_to_FIFO(put_back),
        .old_options_amnt(amnt), .count(count), .done(done)
    );

    option_queue #(.SIZE(SIZE), .DEPTH(4)) u_small (
        .clk(clk), .rst(rst),
        .load_valid(s_load_valid), .load_is_index(s_load_is_index), .load_data(s_load_data),
        .load_ready(s_load_ready), .load_done(s_load_done),
        .option(s_option), .option_is_index(s_option_is_index), .valid_op(s_valid_op),
        .valid_out(s_valid_out), .put_back_to_FIFO(s_put_back),
        .old_options_amnt(s_amnt), .count(s_count), .done(s_done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the stored stream as a plain queue plus per-line totals.
    logic [SIZE:0] ld[$];
    logic [SIZE:0] mq[$];
    int            m_amnt[NL];
    int            m_cur;
    bit            m_fpd, m_ds;
    int            seen_011;

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < NL; i++) m_amnt[i] = 0;
        m_cur = 0; m_fpd = 1'b0; m_ds = 1'b0; seen_011 = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        load_valid = 1'b0; load_done = 1'b0; valid_out = 1'b0; put_back = 1'b0;
        s_load_valid = 1'b0; s_load_done = 1'b0; s_valid_out = 1'b0; s_put_back = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic load_directed_list();
        ld.delete();
        ld.push_back(4'b1000); ld.push_back(4'b0101); ld.push_back(4'b0011);
        ld.push_back(4'b1001); ld.push_back(4'b0110);
    endtask

    // Streams ld into the main DUT one entry per cycle, then pulses load_done.
    task automatic load_stream();
        int line = 0;
        logic [SIZE:0] t;
        for (int i = 0; i < ld.size(); i++) begin
            t = ld[i];
            load_valid = 1'b1; load_is_index = t[SIZE]; load_data = t[SIZE-1:0];
            mq.push_back(t);
            if (t[SIZE]) line = int'(t[SIZE-1:0]);
            else if (line < NL && m_amnt[line] < 127) m_amnt[line]++;
            @(negedge clk);
        end
        load_valid = 1'b0; load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
    endtask

    // Plays the solver: mode 0 discards only the first 3'b011, mode 1 gives random verdicts/delays.
    task automatic run_replay(input int mode, input int budget, output bit finished);
        int due = 1;
        int wl = 0;
        bit pending = 1'b0;
        bit keep;
        bit disc_once = 1'b0;
        logic [SIZE:0] e, pe;
        finished = 1'b0;
        pe = '0;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            valid_out = 1'b0; put_back = 1'b0;
            if (due > 0) due--;
            if (due == 0) begin
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL model_empty: model queue drained, dut count=%0d", count);
                    finished = 1'b1;
                end else begin
                    e = mq[0];
                    if (e[SIZE] && e[SIZE-1:0] == '0 && m_fpd && !m_ds) begin
                        checks++;
                        if (done !== 1'b1 || valid_op !== 1'b0) begin
                            errors++;
                            $display("FAIL converge: done=%0b valid_op=%0b, expected done=1 valid_op=0", done, valid_op);
                        end
                        finished = 1'b1;
                    end else begin
                        void'(mq.pop_front());
                        checks++;
                        if (valid_op !== 1'b1 || option_is_index !== e[SIZE] || option !== e[SIZE-1:0]) begin
                            errors++;
                            $display("FAIL issue: got vop=%0b idx=%0b data=%b, expected vop=1 idx=%0b data=%b",
                                     valid_op, option_is_index, option, e[SIZE], e[SIZE-1:0]);
                        end
                        if (e[SIZE]) begin
                            mq.push_back(e);
                            m_cur = int'(e[SIZE-1:0]);
                            if (m_cur == 0) begin m_fpd = 1'b1; m_ds = 1'b0; end
                            due = 1;
                            for (int i = 0; i < NL; i++) begin
                                checks++;
                                if (int'(amnt[i]) !== m_amnt[i]) begin
                                    errors++;
                                    $display("FAIL amnt[%0d]: got %0d, expected %0d", i, amnt[i], m_amnt[i]);
                                end
                            end
                        end else begin
                            if (e[SIZE-1:0] == 3'b011) seen_011++;
                            pe = e; pending = 1'b1; due = -1;
                            wl = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
                        end
                        checks++;
                        if (int'(count) !== mq.size()) begin
                            errors++;
                            $display("FAIL count_at_issue: got %0d, expected %0d", count, mq.size());
                        end
                    end
                end
            end else begin
                checks++;
                if (valid_op !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_vop: got valid_op=%0b, expected 0", valid_op);
                end
            end
            if (pending && !finished) begin
                if (wl == 0) begin
                    if (mode == 1) keep = ($urandom_range(0, 3) != 0);
                    else keep = !(pe == 4'b0011 && !disc_once);
                    if (!keep) disc_once = 1'b1;
                    valid_out = 1'b1; put_back = keep;
                    pending = 1'b0; due = 2;
                    if (keep) mq.push_back(pe);
                    else begin
                        if (m_amnt[m_cur] > 0) m_amnt[m_cur]--;
                        m_ds = 1'b1;
                    end
                end else begin
                    wl--;
                end
            end
        end
        valid_out = 1'b0; put_back = 1'b0;
        if (!finished) begin
            checks++; errors++;
            $display("FAIL replay_timeout: no convergence within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (count !== 7'd0 || load_ready !== 1'b1 || valid_op !== 1'b0 || done !== 1'b0 ||
            option !== 3'd0 || option_is_index !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: count=%0d ready=%0b vop=%0b done=%0b opt=%b idx=%0b, expected 0 1 0 0 000 0",
                     count, load_ready, valid_op, done, option, option_is_index);
        end
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (amnt[i] !== 7'd0) begin
                errors++;
                $display("FAIL reset_amnt[%0d]: got %0d, expected 0", i, amnt[i]);
            end
        end
    endtask

    task automatic test_directed();
        bit fin;
        reset_dut();
        load_directed_list();
        load_stream();
        checks++;
        if (count !== 7'd5 || amnt[0] !== 7'd2 || amnt[1] !== 7'd1) begin
            errors++;
            $display("FAIL load_totals: count=%0d amnt0=%0d amnt1=%0d, expected 5 2 1", count, amnt[0], amnt[1]);
        end
        run_replay(0, 200, fin);
        checks++;
        if (count !== 7'd4 || amnt[0] !== 7'd1 || amnt[1] !== 7'd1) begin
            errors++;
            $display("FAIL after_discard: count=%0d amnt0=%0d amnt1=%0d, expected 4 1 1", count, amnt[0], amnt[1]);
        end
        checks++;
        if (seen_011 !== 1) begin
            errors++;
            $display("FAIL reissue_011: issued %0d times, expected 1", seen_011);
        end
        // Inputs in DONE must be ignored.
        for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1; load_is_index = 1'b0; load_data = 3'b111;
            valid_out = 1'b1; put_back = 1'b0;
            @(negedge clk);
            checks++;
            if (valid_op !== 1'b0 || done !== 1'b1 || count !== 7'd4 || amnt[0] !== 7'd1) begin
                errors++;
                $display("FAIL done_hold: vop=%0b done=%0b count=%0d amnt0=%0d, expected 0 1 4 1",
                         valid_op, done, count, amnt[0]);
            end
        end
        load_valid = 1'b0; valid_out = 1'b0;
    endtask

    task automatic test_random();
        bit fin;
        int n;
        for (int it = 0; it < 5; it++) begin
            reset_dut();
            ld.delete();
            ld.push_back(4'b1000);
            n = $urandom_range(6, 18);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) ld.push_back({1'b1, 3'($urandom_range(1, 5))});
                else ld.push_back({1'b0, 3'($urandom_range(0, 7))});
            end
            load_stream();
            checks++;
            if (int'(count) !== ld.size()) begin
                errors++;
                $display("FAIL rand_load_count: got %0d, expected %0d", count, ld.size());
            end
            run_replay(1, 4000, fin);
        end
    endtask

    task automatic test_wait_stall();
        bit got = 1'b0;
        reset_dut();
        ld.delete();
        ld.push_back(4'b1000); ld.push_back(4'b0101); ld.push_back(4'b1001); ld.push_back(4'b0110);
        load_stream();
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (valid_op === 1'b1 && option_is_index === 1'b0) got = 1'b1;
        end
        checks++;
        if (!got || option !== 3'b101 || count !== 7'd3) begin
            errors++;
            $display("FAIL stall_first_option: got=%0b opt=%b count=%0d, expected 1 101 3", got, option, count);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (valid_op !== 1'b0 || count !== 7'd3 || amnt[0] !== 7'd1 || amnt[1] !== 7'd1) begin
                errors++;
                $display("FAIL stall_hold: vop=%0b count=%0d amnt0=%0d amnt1=%0d, expected 0 3 1 1",
                         valid_op, count, amnt[0], amnt[1]);
            end
        end
        valid_out = 1'b1; put_back = 1'b1;
        @(negedge clk);
        valid_out = 1'b0; put_back = 1'b0;
        checks++;
        if (valid_op !== 1'b0 || count !== 7'd4) begin
            errors++;
            $display("FAIL stall_verdict: vop=%0b count=%0d, expected 0 4", valid_op, count);
        end
        @(negedge clk);
        checks++;
        if (valid_op !== 1'b1 || option_is_index !== 1'b1 || option !== 3'd1 || count !== 7'd4) begin
            errors++;
            $display("FAIL stall_resume: vop=%0b idx=%0b opt=%0d count=%0d, expected 1 1 1 4",
                     valid_op, option_is_index, option, count);
        end
    endtask

    task automatic test_overflow();
        logic [SIZE:0] ents[6];
        logic [SIZE:0] t;
        int n = 0;
        ents[0] = 4'b1000; ents[1] = 4'b0001; ents[2] = 4'b0010;
        ents[3] = 4'b0011; ents[4] = 4'b0100; ents[5] = 4'b0111;
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (s_load_ready !== (i < 4)) begin
                errors++;
                $display("FAIL small_ready[%0d]: got %0b, expected %0b", i, s_load_ready, (i < 4));
            end
            t = ents[i];
            s_load_valid = 1'b1; s_load_is_index = t[SIZE]; s_load_data = t[SIZE-1:0];
            @(negedge clk);
        end
        s_load_valid = 1'b0;
        checks++;
        if (s_load_ready !== 1'b0 || s_count !== 3'd4 || s_amnt[0] !== 7'd3) begin
            errors++;
            $display("FAIL small_full: ready=%0b count=%0d amnt0=%0d, expected 0 4 3", s_load_ready, s_count, s_amnt[0]);
        end
        s_load_done = 1'b1;
        @(negedge clk);
        s_load_done = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            s_valid_out = 1'b0; s_put_back = 1'b0;
            if (s_valid_op === 1'b1) begin
                t = ents[n];
                checks++;
                if (s_option_is_index !== t[SIZE] || s_option !== t[SIZE-1:0]) begin
                    errors++;
                    $display("FAIL small_issue[%0d]: got idx=%0b data=%b, expected idx=%0b data=%b",
                             n, s_option_is_index, s_option, t[SIZE], t[SIZE-1:0]);
                end
                if (s_option_is_index === 1'b0) begin
                    s_valid_out = 1'b1; s_put_back = 1'b1;
                end
                n++;
            end
        end
        s_valid_out = 1'b0; s_put_back = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL small_issue_count: got %0d issues, expected 4", n);
        end
    endtask

    task automatic test_reset_in_wait();
        bit got = 1'b0;
        bit fin;
        reset_dut();
        load_directed_list();
        load_stream();
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (valid_op === 1'b1 && option_is_index === 1'b0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rstwait_reach: got=%0b, expected 1", got);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (count !== 7'd0 || done !== 1'b0 || load_ready !== 1'b1 || valid_op !== 1'b0 || amnt !== '0) begin
            errors++;
            $display("FAIL rstwait_values: count=%0d done=%0b ready=%0b vop=%0b amnt=%h, expected 0 0 1 0 0",
                     count, done, load_ready, valid_op, amnt);
        end
        model_clear();
        load_directed_list();
        load_stream();
        run_replay(0, 200, fin);
        checks++;
        if (seen_011 !== 1 || count !== 7'd4) begin
            errors++;
            $display("FAIL rstwait_replay: seen_011=%0d count=%0d, expected 1 4", seen_011, count);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wait_stall();
        test_overflow();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/option_queue.md
# option_queue

Circular option queue feeding the FIFO-based line solver. It is the transmitter side of the solver's option stream. It is loaded once with a tagged stream of line-index markers and candidate line options. It then replays that stream to the solver one entry at a time and requeues each option according to the solver's verdict. It also maintains the per-line option counts the solver consumes, and flags completion when a full pass eliminates nothing.

## Interface
- SIZE, 3: board side length; options are SIZE bits; lines 0..2*SIZE-1 (rows first, then columns). Requires SIZE ≥ clog2(2*SIZE).
- DEPTH, 64: queue entries; power of two.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load entry present.
- load_is_index  in  1  1 = line-index marker, 0 = option.
- load_data  in  SIZE  option bits, or line index zero-extended.
- load_ready  out  1  entry accepted this cycle when load_valid & load_ready.
- load_done  in  1  one-cycle pulse ending the load phase.
- option  out  SIZE  entry presented to the solver.
- option_is_index  out  1  tag of the presented entry.
- valid_op  out  1  one-cycle strobe: option/option_is_index valid.
- valid_out  in  1  solver verdict strobe for the last issued option.
- put_back_to_FIFO  in  1  sampled with valid_out; 1 = keep, 0 = discard.
- old_options_amnt  out  [2*SIZE:0][6:0]  live option count per line.
- count  out  clog2(DEPTH)+1  entries currently stored.
- done  out  1  solve converged; held until reset.

## Operation
- States: LOAD, ISSUE, WAIT, DONE. Reset enters LOAD.
- LOAD:
  - load_ready = (count < DEPTH).
  - Each accepted entry is written at the tail.
  - An index entry sets load_line.
  - An option entry increments old_options_amnt[load_line], saturating at 127. Options before any index count toward line 0.
  - load_done moves to ISSUE; it is ignored if count == 0 (stays LOAD).
- ISSUE:
  - Pops the head. Drives option, option_is_index and valid_op = 1 for exactly that cycle.
  - Index entry:
    - Pushed back to the tail in the same cycle (count unchanged) and latched as cur_line; stays ISSUE.
    - If its index is 0, this is a pass boundary. If first_pass_done & ~discard_seen, go DONE and do not issue this entry.
    - Otherwise set first_pass_done and clear discard_seen.
  - Option entry: moves to WAIT; count decrements.
- WAIT:
  - valid_op = 0. Waits indefinitely for valid_out.
  - On valid_out with put_back_to_FIFO = 1: the option is pushed to the tail and count is restored.
  - On valid_out with put_back_to_FIFO = 0: the option is dropped, old_options_amnt[cur_line] decrements (floor 0), and discard_seen is set.
  - Either verdict returns to ISSUE the next cycle.
- DONE: done = 1; no further issues; all inputs ignored.
- Ignored inputs: load_valid/load_done outside LOAD, and valid_out outside WAIT.
- Pointers wrap modulo DEPTH. A WAIT-state push-back can never overflow, because the head was popped.

## Timing
- Reset values:
  - option = 0, option_is_index = 0, valid_op = 0, done = 0, count = 0, all old_options_amnt = 0.
  - load_ready = 1, because the block is in LOAD with an empty queue.
  - Head and tail pointers = 0; first_pass_done = 0; discard_seen = 0.
- Outputs are registered, except load_ready, which is a combinational function of state and count.
- Load throughput: 1 entry/cycle.
- Index entry issue: 1 cycle; back-to-back index entries issue on consecutive cycles.
- Option entry: issue cycle, then WAIT. The next issue occurs in the cycle after valid_out. If valid_out arrives in the first WAIT cycle, an option occupies a minimum of 2 cycles.
- old_options_amnt and count update in the cycle after the causing event.
- Reset mid-operation (any state): full return to reset values on the next edge; queue contents are discarded.

## Test plan
- Load entries: idx0, 3'b101, 3'b011, idx1, 3'b110, then load_done.
  - Expect count = 5, amnt[0] = 2, amnt[1] = 1.
  - Expect the issue order idx0, 101, 011, idx1, 110, idx0, …
- Solver returns put_back = 0 on the first 3'b011 and 1 on all others.
  - Expect amnt[0] = 1 and count = 4.
  - Expect 3'b011 is never issued again.
- All verdicts are put_back = 1 after the first pass.
  - Expect done = 1 at the second idx0 following a pass with no discards.
  - Expect idx0 not issued, and valid_op held at 0 thereafter.
- DEPTH = 4: hold load_valid for 6 entries.
  - Expect load_ready = 0 after 4 accepted entries.
  - Expect entries 5–6 not stored and count = 4.
- Withhold valid_out for 20 cycles in WAIT.
  - Expect valid_op = 0 throughout, with count and amnt stable.
  - Expect a pulse of valid_out with put_back = 1 to resume issue on the next cycle.
- Assert rst while in WAIT.
  - Expect count = 0, all amnt = 0, done = 0, load_ready = 1 on the next cycle.
  - Expect a fresh load to replay correctly.
